// File: rtl/enemy_slot_scheduler_pkg.sv
// enemy_slot_scheduler_pkg: shared defaults, FSM encoding and index-width helper.
// Rev 1.0
`default_nettype none

package enemy_slot_scheduler_pkg;

  localparam int SLOT_COUNT       = 4;
  localparam int X_WIDTH          = 10;
  localparam int TYPE_WIDTH       = 2;
  localparam int SPAWN_X_DEFAULT  = 639;
  localparam int SPEED_DEFAULT    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  // Width of a slot index; never zero so a single-slot build still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_slot_scheduler_if.sv
// enemy_slot_scheduler_if: step/spawn strobes in, registered slot table out.
// Rev 1.0
`default_nettype none

interface enemy_slot_scheduler_if
  import enemy_slot_scheduler_pkg::*;
#(
  parameter int SLOTS = SLOT_COUNT,
  parameter int XW    = X_WIDTH,
  parameter int TW    = TYPE_WIDTH
);
  logic                tick;
  logic                gen_req;
  logic [TW-1:0]       gen_type;
  logic                clear;
  logic [SLOTS-1:0]    slot_valid;
  logic [SLOTS*XW-1:0] slot_x;
  logic [SLOTS*TW-1:0] slot_type;
  logic                busy;
  logic                step_done;
  logic                drop;
  logic                overrun;

  modport master (
    output tick, gen_req, gen_type, clear,
    input  slot_valid, slot_x, slot_type, busy, step_done, drop, overrun
  );

  modport slave (
    input  tick, gen_req, gen_type, clear,
    output slot_valid, slot_x, slot_type, busy, step_done, drop, overrun
  );
endinterface

`default_nettype wire

// File: rtl/enemy_slot_scheduler_free_slot_finder.sv
// enemy_slot_scheduler_free_slot_finder: lowest-index free slot priority encoder.
// Rev 1.0
`default_nettype none

module enemy_slot_scheduler_free_slot_finder
  import enemy_slot_scheduler_pkg::*;
#(
  parameter int SLOTS = SLOT_COUNT,
  parameter int IW    = idx_width(SLOT_COUNT)
) (
  input  logic [SLOTS-1:0] valid,
  output logic             any_free,
  output logic [IW-1:0]    free_idx
);
  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/enemy_slot_scheduler.sv
// enemy_slot_scheduler: per-step obstacle move/retire walk followed by one spawn.
// Rev 1.0 -- SPAWN_HOLD_EN keeps a spawn pending when all slots are full.
`default_nettype none

module enemy_slot_scheduler
  import enemy_slot_scheduler_pkg::*;
#(
  parameter int              SLOTS   = SLOT_COUNT,
  parameter int              XW      = X_WIDTH,
  parameter logic [XW-1:0]   SPAWN_X = XW'(SPAWN_X_DEFAULT),
  parameter logic [XW-1:0]   SPEED   = XW'(SPEED_DEFAULT),
  parameter int              TW      = TYPE_WIDTH
) (
  input logic                   clock,
  input logic                   rst,
  enemy_slot_scheduler_if.slave bus
);
  localparam int IW = idx_width(SLOTS);

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic [SLOTS-1:0] valid;
  logic [XW-1:0]    xpos [SLOTS];
  logic [TW-1:0]    kind [SLOTS];
  logic             pending;
  logic [TW-1:0]    pend_type;
  logic             busy_q;
  logic             step_done_q;
  logic             drop_q;
  logic             overrun_q;
  logic             any_free;
  logic [IW-1:0]    free_idx;
  logic             consumed;
  logic             last_slot;

  assign last_slot = (idx == IW'(SLOTS - 1));

  // The valid vector seen in SPAWN already includes this step's retirements.
  enemy_slot_scheduler_free_slot_finder #(
    .SLOTS (SLOTS),
    .IW    (IW)
  ) u_finder (
    .valid    (valid),
    .any_free (any_free),
    .free_idx (free_idx)
  );

`ifdef SPAWN_HOLD_EN
  assign consumed = (state == SPAWN) && pending && any_free;
`else
  assign consumed = (state == SPAWN) && pending;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.tick) state_next = MOVE;
        MOVE:    if (last_slot) state_next = SPAWN;
        SPAWN:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      valid       <= '0;
      pending     <= 1'b0;
      pend_type   <= '0;
      step_done_q <= 1'b0;
      drop_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        xpos[i] <= '0;
        kind[i] <= '0;
      end
    end else if (bus.clear) begin
      idx         <= '0;
      valid       <= '0;
      pending     <= 1'b0;
      pend_type   <= '0;
      step_done_q <= 1'b0;
      drop_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        xpos[i] <= '0;
        kind[i] <= '0;
      end
    end else begin
      step_done_q <= 1'b0;
      drop_q      <= 1'b0;
      pending     <= (pending & ~consumed) | bus.gen_req;
      if (bus.gen_req) pend_type <= bus.gen_type;
      if (bus.tick && state != IDLE) overrun_q <= 1'b1;

      case (state)
        MOVE: begin
          idx <= last_slot ? '0 : idx + IW'(1);
          if (valid[idx]) begin
            if (xpos[idx] > SPEED) begin
              xpos[idx] <= xpos[idx] - SPEED;
            end else begin
              valid[idx] <= 1'b0;
              xpos[idx]  <= '0;
            end
          end
        end
        SPAWN: begin
          step_done_q <= 1'b1;
          if (pending) begin
            if (any_free) begin
              valid[free_idx] <= 1'b1;
              xpos[free_idx]  <= SPAWN_X;
              kind[free_idx]  <= pend_type;
            end else begin
`ifndef SPAWN_HOLD_EN
              drop_q <= 1'b1;
`endif
            end
          end
        end
        default: idx <= '0;
      endcase
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign bus.slot_x[g*XW +: XW]    = xpos[g];
    assign bus.slot_type[g*TW +: TW] = kind[g];
  end

  assign bus.slot_valid = valid;
  assign bus.busy       = busy_q;
  assign bus.step_done  = step_done_q;
  assign bus.drop       = drop_q;
  assign bus.overrun    = overrun_q;
endmodule

`default_nettype wire

// File: tb/tb_enemy_slot_scheduler.sv
// tb_enemy_slot_scheduler: directed scenarios for the obstacle slot scheduler.
// Rev 1.0
`default_nettype none

module tb_enemy_slot_scheduler;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   drop_cnt = 0;

  always #5 clock = ~clock;

  enemy_slot_scheduler_if bus ();

  enemy_slot_scheduler dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  function automatic logic [9:0] xof(input int i);
    return bus.slot_x[i*10 +: 10];
  endfunction

  function automatic logic [1:0] tof(input int i);
    return bus.slot_type[i*2 +: 2];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_req(input logic [1:0] t);
    bus.gen_req  = 1'b1;
    bus.gen_type = t;
    cyc();
    bus.gen_req  = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  // Issues one tick and waits (bounded) for step_done; lat is cycles after the tick edge.
  task automatic run_step(output int lat);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    lat = 0;
    while (!bus.step_done && lat < 20) begin
      cyc();
      lat++;
      if (bus.drop) drop_cnt++;
    end
  endtask

  task automatic test_reset();
    int lat;
    checks++;
    if (bus.slot_valid !== 4'b0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b ovr=%b required all 0", bus.slot_valid, bus.busy, bus.step_done, bus.overrun);
    end
    cyc();
    rst = 1'b1;
    cyc();
    pulse_req(2'd1);
    run_step(lat);
    // Start a second step and assert reset while slot 2 is being processed.
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.slot_valid !== 4'b0 || bus.slot_x !== 40'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_move: valid=%b x=%h busy=%b required 0/0/0", bus.slot_valid, bus.slot_x, bus.busy);
    end
    cyc();
    rst = 1'b1;
    cyc();
    pulse_req(2'd3);
    run_step(lat);
    checks++;
    if (lat !== 5 || bus.slot_valid !== 4'b0001) begin
      errors++;
      $display("FAIL reset_restart: lat=%0d valid=%b required 5 0001", lat, bus.slot_valid);
    end
    do_clear();
  endtask

  task automatic test_spawn_and_move();
    int lat;
    pulse_req(2'd2);
    run_step(lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL spawn_latency: got %0d required 5", lat);
    end
    checks++;
    if (bus.slot_valid !== 4'b0001 || xof(0) !== 10'd639 || tof(0) !== 2'd2) begin
      errors++;
      $display("FAIL spawn_slot0: valid=%b x=%0d type=%0d required 0001 639 2", bus.slot_valid, xof(0), tof(0));
    end
    cyc();
    checks++;
    if (bus.step_done !== 1'b0) begin
      errors++;
      $display("FAIL step_done_width: got %b required 0", bus.step_done);
    end
    run_step(lat);
    checks++;
    if (bus.slot_valid !== 4'b0001 || xof(0) !== 10'd635) begin
      errors++;
      $display("FAIL move_slot0: valid=%b x=%0d required 0001 635", bus.slot_valid, xof(0));
    end
  endtask

  task automatic test_retire_reuse();
    int lat;
    for (int s = 0; s < 157; s++) run_step(lat);
    checks++;
    if (bus.slot_valid !== 4'b0001 || xof(0) !== 10'd7) begin
      errors++;
      $display("FAIL walk_to_7: valid=%b x=%0d required 0001 7", bus.slot_valid, xof(0));
    end
    run_step(lat);
    checks++;
    if (bus.slot_valid !== 4'b0001 || xof(0) !== 10'd3) begin
      errors++;
      $display("FAIL walk_to_3: valid=%b x=%0d required 0001 3", bus.slot_valid, xof(0));
    end
    pulse_req(2'd3);
    run_step(lat);
    checks++;
    if (bus.slot_valid !== 4'b0001 || xof(0) !== 10'd639 || tof(0) !== 2'd3) begin
      errors++;
      $display("FAIL retire_reuse: valid=%b x=%0d type=%0d required 0001 639 3", bus.slot_valid, xof(0), tof(0));
    end
  endtask

  task automatic test_spawn_cycle_req();
    int lat;
    do_clear();
    pulse_req(2'd1);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    // The next edge is the SPAWN cycle.
    bus.gen_req  = 1'b1;
    bus.gen_type = 2'd2;
    cyc();
    bus.gen_req  = 1'b0;
    checks++;
    if (bus.step_done !== 1'b1 || bus.slot_valid !== 4'b0001 || tof(0) !== 2'd1) begin
      errors++;
      $display("FAIL spawn_cycle_first: done=%b valid=%b type=%0d required 1 0001 1", bus.step_done, bus.slot_valid, tof(0));
    end
    run_step(lat);
    checks++;
    if (bus.slot_valid !== 4'b0011 || xof(1) !== 10'd639 || tof(1) !== 2'd2 || xof(0) !== 10'd635) begin
      errors++;
      $display("FAIL spawn_cycle_second: valid=%b x1=%0d t1=%0d x0=%0d required 0011 639 2 635", bus.slot_valid, xof(1), tof(1), xof(0));
    end
    run_step(lat);
    checks++;
    if (bus.slot_valid !== 4'b0011) begin
      errors++;
      $display("FAIL spawn_cycle_no_third: valid=%b required 0011", bus.slot_valid);
    end
  endtask

  task automatic test_full_slots();
    int lat;
    do_clear();
    for (int s = 0; s < 4; s++) begin
      pulse_req(2'(s));
      run_step(lat);
    end
    checks++;
    if (bus.slot_valid !== 4'b1111 || xof(0) !== 10'd627 || xof(3) !== 10'd639 || tof(3) !== 2'd3) begin
      errors++;
      $display("FAIL fill: valid=%b x0=%0d x3=%0d t3=%0d required 1111 627 639 3", bus.slot_valid, xof(0), xof(3), tof(3));
    end
    drop_cnt = 0;
    pulse_req(2'd1);
    run_step(lat);
    checks++;
`ifdef SPAWN_HOLD_EN
    if (drop_cnt !== 0) begin
`else
    if (drop_cnt !== 1) begin
`endif
      errors++;
      $display("FAIL full_drop: drops=%0d", drop_cnt);
    end
    for (int s = 0; s < 156; s++) run_step(lat);
    checks++;
`ifdef SPAWN_HOLD_EN
    if (drop_cnt !== 0 || bus.slot_valid !== 4'b1111 || xof(0) !== 10'd639 || tof(0) !== 2'd1) begin
      errors++;
      $display("FAIL hold_respawn: drops=%0d valid=%b x0=%0d t0=%0d required 0 1111 639 1", drop_cnt, bus.slot_valid, xof(0), tof(0));
    end
`else
    if (drop_cnt !== 1 || bus.slot_valid !== 4'b1110 || xof(0) !== 10'd0) begin
      errors++;
      $display("FAIL drop_no_respawn: drops=%0d valid=%b x0=%0d required 1 1110 0", drop_cnt, bus.slot_valid, xof(0));
    end
`endif
    checks++;
    if (xof(1) !== 10'd3 || xof(3) !== 10'd11) begin
      errors++;
      $display("FAIL full_ages: x1=%0d x3=%0d required 3 11", xof(1), xof(3));
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL full_latency: got %0d required 5", lat);
    end
  endtask

  task automatic test_overrun_clear();
    int dones;
    do_clear();
    pulse_req(2'd2);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.step_done) dones++;
      cyc();
    end
    checks++;
    if (dones !== 1 || bus.overrun !== 1'b1 || bus.slot_valid !== 4'b0001) begin
      errors++;
      $display("FAIL overrun: dones=%0d ovr=%b valid=%b required 1 1 0001", dones, bus.overrun, bus.slot_valid);
    end
    bus.clear   = 1'b1;
    bus.gen_req = 1'b1;
    bus.tick    = 1'b1;
    cyc();
    bus.clear   = 1'b0;
    bus.gen_req = 1'b0;
    bus.tick    = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0 || bus.slot_valid !== 4'b0 || bus.slot_x !== 40'd0 || bus.slot_type !== 8'd0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0) begin
      errors++;
      $display("FAIL clear: ovr=%b valid=%b x=%h t=%h busy=%b done=%b required all 0", bus.overrun, bus.slot_valid, bus.slot_x, bus.slot_type, bus.busy, bus.step_done);
    end
    cyc();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_tick_discard: busy=%b required 0", bus.busy);
    end
    run_step(dones);
    checks++;
    if (bus.slot_valid !== 4'b0) begin
      errors++;
      $display("FAIL clear_req_discard: valid=%b required 0000", bus.slot_valid);
    end
  endtask

  initial begin
    bus.tick     = 1'b0;
    bus.gen_req  = 1'b0;
    bus.gen_type = 2'd0;
    bus.clear    = 1'b0;
    #2;
    test_reset();
    test_spawn_and_move();
    test_retire_reuse();
    test_spawn_cycle_req();
    test_full_slots();
    test_overrun_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/enemy_slot_scheduler.md
Name: enemy_slot_scheduler

Overview:
- Sequences the obstacle slots of the game-state datapath once per game step.
- Walks each slot to advance its x position and retire off-screen obstacles, then services a pending spawn request (from check_gen_enemy's togenerate) into the lowest free slot.
- Sits between the step/spawn strobes and the VGA renderer, which reads the registered slot outputs.

Parameters:
- SLOTS, 4, number of obstacle slots
- XW, 10, x-position width (bits)
- SPAWN_X, 10'd639, x loaded into a newly spawned slot
- SPEED, 10'd4, pixels subtracted per step
- TW, 2, obstacle type width

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick  in  1  game-step strobe, one clock wide, synchronous to clock
- gen_req  in  1  spawn request (togenerate), sampled every cycle
- gen_type  in  TW  obstacle type, captured with gen_req
- clear  in  1  synchronous game-over/restart clear
- slot_valid  out  SLOTS  per-slot occupied flag
- slot_x  out  SLOTS*XW  packed x positions; slot i at [i*XW +: XW]
- slot_type  out  SLOTS*TW  packed types
- busy  out  1  high whenever the FSM is not IDLE
- step_done  out  1  one-cycle pulse at the end of each step
- drop  out  1  one-cycle pulse when a spawn is discarded
- overrun  out  1  sticky; set when a tick arrives while busy; cleared by clear

Behaviour:
- Reset (rst=0, async): FSM=IDLE; idx=0; pending=0; all outputs 0.
- FSM states:
  - IDLE: on tick go to MOVE with idx=0.
  - MOVE: processes slot idx in one cycle; idx increments; after idx==SLOTS-1 go to SPAWN.
  - SPAWN: one cycle, then IDLE with step_done=1.
  - Step latency: tick in IDLE produces step_done exactly SLOTS+1 cycles later.
- MOVE per slot:
  - valid and x > SPEED: x <= x - SPEED.
  - valid and x <= SPEED: valid <= 0, x <= 0 (retire; never wraps).
  - Invalid slot: unchanged.
- pending request latch:
  - next = (pending & ~consumed) | gen_req.
  - gen_type is captured into pend_type whenever gen_req=1; the last request wins.
  - Multiple requests between steps merge into one spawn.
  - A gen_req in the SPAWN cycle stays pending for the next step.
- SPAWN:
  - If pending, find the lowest-index slot whose valid is 0 after this step's moves; a slot retired in this step is reusable.
  - Load that slot with valid=1, x=SPAWN_X, type=pend_type, and consume pending.
  - If no slot is free: see Optional Feature.
  - If pending=0: no change.
- tick while busy: ignored (no restart, no queueing); overrun <= 1.
- clear:
  - Highest priority, any state.
  - Next cycle: all slot_valid/x/type = 0, pending=0, overrun=0, FSM=IDLE, idx=0.
  - No step_done or drop pulse in that cycle.
  - tick or gen_req in the same cycle as clear are discarded.
- All outputs are registered; slot outputs change only in MOVE/SPAWN/clear cycles.
- Arithmetic is unsigned XW-bit; SPAWN_X > SPEED is required.

Optional Feature:
- Macro: SPAWN_HOLD_EN.
- Defined: on a full-slots SPAWN, pending stays set and the spawn is retried at the next step's SPAWN; drop never pulses.
- Undefined: on a full-slots SPAWN, pending is cleared and drop pulses for one cycle.

Decomposition:
- define.v (shared include) holds:
  - SLOT_COUNT, slot x/type widths, SPAWN_X, SPEED defaults.
  - FSM state encodings: IDLE=2'd0, MOVE=2'd1, SPAWN=2'd2.
- Sub-module free_slot_finder: combinational priority encoder.
  - Inputs: SLOTS-bit valid vector.
  - Outputs: any_free and the lowest free index ($clog2(SLOTS) bits).

Test Plan:
- Reset mid-MOVE: deassert rst at idx=2 -> outputs all 0 immediately; FSM IDLE; next tick starts at idx=0.
- gen_req=1 with gen_type=2, then tick -> step_done 5 cycles after tick; slot0 valid, x=639, type=2; next tick -> x=635.
- Slot0 at x=4, tick -> slot0 retired (valid=0, x=0); a pending spawn in the same step reuses slot0 at x=639.
- All 4 slots valid with x>4, gen_req, tick:
  - Undefined macro: drop pulses once; pending=0.
  - SPAWN_HOLD_EN: no drop; spawn lands in the first slot that retires in a later step.
- tick again 2 cycles after an accepted tick -> overrun=1; step_done only once; clear -> overrun=0 and all slots 0.
- gen_req asserted exactly in the SPAWN cycle while pending=1 -> one spawn this step, a second spawn next step.
